pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 99 +++++++++
 tb/tb_pipelined_adder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained chunks, one chunk per register stage.
// Single-cycle advance control: the whole pipeline moves or holds together under output backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] s_new [STAGES];
  logic             c_new [STAGES];
  logic             ovf_new;
  logic             adv;

  assign adv       = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

  // Stage inputs: stage 0 takes the raw operands, later stages take the skewed registers.
  always_comb begin
    logic [CHUNK:0] part;
    part     = '0;
    a_src[0] = in_a;
    b_src[0] = in_sub ? ~in_b : in_b;
    s_src[0] = '0;
    c_src[0] = in_sub | in_cin;
    for (int s = 1; s < STAGES; s++) begin
      a_src[s] = a_q[s-1];
      b_src[s] = b_q[s-1];
      s_src[s] = s_q[s-1];
      c_src[s] = c_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      part = {1'b0, a_src[s][s*CHUNK +: CHUNK]}
           + {1'b0, b_src[s][s*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_src[s]};
      s_new[s]                    = s_src[s];
      s_new[s][s*CHUNK +: CHUNK]  = part[CHUNK-1:0];
      c_new[s]                    = part[CHUNK];
    end
    ovf_new = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
              (s_new[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        s_q[s]   <= '0;
        c_q[s]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      // in_ready equals adv, so in_valid alone marks an accepted operation.
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= a_src[s];
        b_q[s] <= b_src[s];
        s_q[s] <= s_new[s];
        c_q[s] <= c_new[s];
      end
      ovf_q <= ovf_new;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, random streams with backpressure,
// mid-operation reset and a parameter sweep, all checked against a whole-word arithmetic model.
module tb_pipelined_adder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [63:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [63:0] out_sum;

  logic        sw_valid, sw_cin, sw_sub, sw_ready;
  logic [63:0] sw_a, sw_b;
  logic        r8_valid, r8_rdy, r8_cout, r8_ovf;
  logic [7:0]  r8_sum;
  logic        r32_valid, r32_rdy, r32_cout, r32_ovf;
  logic [31:0] r32_sum;
  logic        r64_valid, r64_rdy, r64_cout, r64_ovf;
  logic [63:0] r64_sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } res_t;

  res_t mon_r;
  res_t out_q[$];
  int   acc_q[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8_rdy),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r8_valid), .out_ready(sw_ready), .out_sum(r8_sum),
    .out_cout(r8_cout), .out_ovf(r8_ovf));

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32_rdy),
    .in_a(sw_a[31:0]), .in_b(sw_b[31:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r32_valid), .out_ready(sw_ready), .out_sum(r32_sum),
    .out_cout(r32_cout), .out_ovf(r32_ovf));

  pipelined_adder #(.WIDTH(64), .STAGES(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64_rdy),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r64_valid), .out_ready(sw_ready), .out_sum(r64_sum),
    .out_cout(r64_cout), .out_ovf(r64_ovf));

  always @(posedge clk) cyc <= cyc + 1;

  // Log every output transfer and every accept, tagged with the edge they belong to.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        mon_r.sum  = out_sum;
        mon_r.cout = out_cout;
        mon_r.ovf  = out_ovf;
        mon_r.cyc  = cyc;
        out_q.push_back(mon_r);
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    end
  end

  // Reference: whole-word arithmetic at width w; returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
    logic [64:0] mask, aa, be, full;
    logic        ovf;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    be   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full = aa + be + (sub ? 65'd1 : {64'd0, cin});
    ovf  = (aa[w-1] == be[w-1]) && (full[w-1] != aa[w-1]);
    return {ovf, full[w], full[63:0] & mask[63:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and return once it has been accepted (at posedge+1).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    int guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    n_vec++;
    if ({out_valid, out_cout, out_ovf} !== 3'b000 || out_sum !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid/cout/ovf=%b sum=%h, required 000 and 0",
               {out_valid, out_cout, out_ovf}, out_sum);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] a[4], b[4], e[4];
    a = '{64'd21, 64'd192, 64'd25712, 64'd0};
    b = '{64'd20, 64'd8, 64'd92182163, 64'd92182163};
    e = '{64'd41, 64'd200, 64'd92207875, 64'd92182163};
    out_q.delete(); acc_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(a[i], b[i], 1'b0, 1'b0);
    drain();
    n_vec++;
    if (out_q.size() != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d results required 4", out_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size() && i < acc_q.size(); i++) begin
      n_vec++;
      if (out_q[i].sum !== e[i] || out_q[i].cout !== 1'b0 || out_q[i].ovf !== 1'b0) begin
        n_err++;
        $display("FAIL basic_result[%0d]: sum=%0d cout=%b ovf=%b required sum=%0d cout=0 ovf=0",
                 i, out_q[i].sum, out_q[i].cout, out_q[i].ovf, e[i]);
      end
      n_vec++;
      if (out_q[i].cyc != acc_q[i] + LAT || acc_q[i] != acc_q[0] + i) begin
        n_err++;
        $display("FAIL basic_timing[%0d]: accept edge %0d out edge %0d, required accept %0d out %0d",
                 i, acc_q[i], out_q[i].cyc, acc_q[0] + i, acc_q[0] + i + LAT);
      end
    end
  endtask

  task automatic test_carry_sub();
    logic [63:0] a[6], b[6], e[6];
    logic        ci[6], sb[6], ec[6], eo[6];
    a  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd7,
           64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    b  = '{64'd92182163, 64'd0, 64'd7, 64'd5, 64'd1, 64'd1};
    ci = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    sb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e  = '{64'd92182162, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2,
           64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    ec = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_q.delete(); acc_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(a[i], b[i], ci[i], sb[i]);
    drain();
    n_vec++;
    if (out_q.size() != 6) begin
      n_err++;
      $display("FAIL carry_sub_count: got %0d results required 6", out_q.size());
    end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i].sum !== e[i] || out_q[i].cout !== ec[i] || out_q[i].ovf !== eo[i]) begin
        n_err++;
        $display("FAIL carry_sub[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 i, out_q[i].sum, out_q[i].cout, out_q[i].ovf, e[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [65:0] exp_q[$];
    logic [63:0] a, b;
    logic        ci, sb;
    out_q.delete(); acc_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a  = {$urandom(), $urandom()};
      b  = (i % 5 == 0) ? ~a : {$urandom(), $urandom()};
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_op(64, a, b, ci, sb));
      send(a, b, ci, sb);
    end
    drain();
    n_vec++;
    if (out_q.size() != 30) begin
      n_err++;
      $display("FAIL random_count: got %0d results required 30", out_q.size());
    end
    for (int i = 0; i < 30 && i < out_q.size() && i < acc_q.size(); i++) begin
      n_vec++;
      if ({out_q[i].ovf, out_q[i].cout, out_q[i].sum} !== exp_q[i] || out_q[i].cyc != acc_q[i] + LAT) begin
        n_err++;
        $display("FAIL random[%0d]: ovf/cout/sum=%h at edge %0d, required %h at edge %0d",
                 i, {out_q[i].ovf, out_q[i].cout, out_q[i].sum}, out_q[i].cyc, exp_q[i], acc_q[i] + LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0, got = 0, budget = 0;
    logic        stalled = 1'b0;
    logic [65:0] held = '0;
    out_q.delete(); acc_q.delete();
    while (got < 10 && budget < 400) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if (sent < 10) begin
        in_valid = 1'b1; in_a = 64'(sent + 1); in_b = 64'(2 * (sent + 1)); in_cin = 1'b0; in_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || {out_ovf, out_cout, out_sum} !== held) begin
          n_err++;
          $display("FAIL bp_stable: valid=%b out=%h required valid=1 out=%h",
                   out_valid, {out_ovf, out_cout, out_sum}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_sum !== 64'(3 * (got + 1))) begin
          n_err++;
          $display("FAIL bp_result[%0d]: got %0d required %0d", got, out_sum, 3 * (got + 1));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      stalled = out_valid && !out_ready;
      held    = {out_ovf, out_cout, out_sum};
      tick();
      budget++;
    end
    n_vec++;
    if (got != 10) begin
      n_err++;
      $display("FAIL bp_timeout: received %0d results required 10", got);
    end
    drain();
    n_vec++;
    if (out_q.size() != 10) begin
      n_err++;
      $display("FAIL bp_transfers: got %0d transfers required 10", out_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int rel;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(64'(100 + i), 64'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midop_preload: out_valid=%b required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_cout, out_ovf} !== 3'b000 || out_sum !== 64'd0) begin
      n_err++;
      $display("FAIL midop_reset: valid/cout/ovf=%b sum=%h required 000 and 0",
               {out_valid, out_cout, out_ovf}, out_sum);
    end
    tick();
    rst_n = 1'b1;
    out_q.delete(); acc_q.delete();
    rel = cyc;
    send(64'd1, 64'd1, 1'b0, 1'b0);
    drain();
    n_vec++;
    if (out_q.size() != 1 || acc_q.size() != 1) begin
      n_err++;
      $display("FAIL midop_count: got %0d results %0d accepts required 1 and 1", out_q.size(), acc_q.size());
    end else begin
      n_vec++;
      if (out_q[0].sum !== 64'd2 || acc_q[0] != rel + 1 || out_q[0].cyc != rel + 1 + LAT) begin
        n_err++;
        $display("FAIL midop_after: sum=%0d accept %0d out %0d required sum=2 accept %0d out %0d",
                 out_q[0].sum, acc_q[0], out_q[0].cyc, rel + 1, rel + 1 + LAT);
      end
    end
  endtask

  task automatic test_param_sweep();
    localparam int N = 24;
    logic [65:0] e8[N], e32[N], e64[N];
    int          i8, i32, i64;
    sw_ready = 1'b1;
    for (int t = 0; t < N + 66; t++) begin
      if (t < N) begin
        sw_a = {$urandom(), $urandom()};
        sw_b = {$urandom(), $urandom()};
        sw_cin = 1'($urandom_range(0, 1));
        sw_sub = 1'($urandom_range(0, 1));
        e8[t]  = ref_op(8, sw_a, sw_b, sw_cin, sw_sub);
        e32[t] = ref_op(32, sw_a, sw_b, sw_cin, sw_sub);
        e64[t] = ref_op(64, sw_a, sw_b, sw_cin, sw_sub);
        sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
      @(negedge clk);
      i8 = t - 1; i32 = t - 8; i64 = t - 64;
      n_vec++;
      if ({r8_rdy, r32_rdy, r64_rdy} !== 3'b111) begin
        n_err++;
        $display("FAIL sweep_ready[%0d]: got %b required 111", t, {r8_rdy, r32_rdy, r64_rdy});
      end
      n_vec++;
      if (i8 >= 0 && i8 < N) begin
        if ({r8_valid, r8_ovf, r8_cout, r8_sum} !== {1'b1, e8[i8][65:64], e8[i8][7:0]}) begin
          n_err++;
          $display("FAIL sweep8[%0d]: got %h required %h", i8, {r8_valid, r8_ovf, r8_cout, r8_sum},
                   {1'b1, e8[i8][65:64], e8[i8][7:0]});
        end
      end else if (r8_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sweep8_idle[%0d]: valid=%b required 0", t, r8_valid);
      end
      n_vec++;
      if (i32 >= 0 && i32 < N) begin
        if ({r32_valid, r32_ovf, r32_cout, r32_sum} !== {1'b1, e32[i32][65:64], e32[i32][31:0]}) begin
          n_err++;
          $display("FAIL sweep32[%0d]: got %h required %h", i32, {r32_valid, r32_ovf, r32_cout, r32_sum},
                   {1'b1, e32[i32][65:64], e32[i32][31:0]});
        end
      end else if (r32_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sweep32_idle[%0d]: valid=%b required 0", t, r32_valid);
      end
      n_vec++;
      if (i64 >= 0 && i64 < N) begin
        if ({r64_valid, r64_ovf, r64_cout, r64_sum} !== {1'b1, e64[i64]}) begin
          n_err++;
          $display("FAIL sweep64[%0d]: got %h required %h", i64, {r64_valid, r64_ovf, r64_cout, r64_sum},
                   {1'b1, e64[i64]});
        end
      end else if (r64_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sweep64_idle[%0d]: valid=%b required 0", t, r64_valid);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ready = 1'b1;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_carry_sub();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
